// File: rtl/ysyx_22040759_ifu_pkg.sv
// Shared constants for the instruction fetch unit: FSM encodings and reset fetch address.
package ysyx_22040759_ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_HOLD = 2'b11
  } ifu_state_t;

  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

  // Instruction fetches are always word aligned.
  function automatic logic [63:0] align_pc(input logic [63:0] a);
    return a & ~64'd3;
  endfunction

endpackage

// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: one outstanding imem request, holds one instruction for decode.
// Redirects from execute replace the pc and discard any response already in flight.
module ysyx_22040759_ifu
  import ysyx_22040759_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  ifu_state_t  state;
  logic [63:0] pc;
  logic        drop;
  logic [63:0] redirect_target;

  assign redirect_target = align_pc(redirect_pc);

  assign imem_req_valid = (state == ST_REQ);
  assign inst_valid     = (state == ST_HOLD);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= align_pc(RESET_PC);
      drop    <= 1'b0;
      inst    <= 32'h0;
      inst_pc <= align_pc(RESET_PC);
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect_valid) pc <= redirect_target;
          state <= ST_REQ;
        end

        ST_REQ: begin
          // A redirect racing an accepted request: the old address is already
          // in memory, so its response must be thrown away.
          if (redirect_valid) pc <= redirect_target;
          if (imem_req_ready) begin
            state <= ST_WAIT;
            if (redirect_valid) drop <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_target;
            if (imem_resp_valid) begin
              drop  <= 1'b0;
              state <= ST_REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= ST_REQ;
            end else begin
              inst    <= imem_resp_data;
              inst_pc <= pc;
              state   <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_target;
            state <= ST_REQ;
          end else if (inst_ready) begin
            pc    <= pc + 64'd4;
            state <= ST_REQ;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
